// File: rtl/lpm_pkg.sv
// Shared types for the longest-prefix-match table: entry layout, FSM encoding, match helper.
// Used by lpm_table_ctrl (optional counters under `LPM_STATS_EN) and lpm_chunk_match.
package lpm_pkg;

    localparam int NUM_ENTRIES_DEF       = 32;
    localparam int ENTRIES_PER_CYCLE_DEF = 4;
    localparam int IDX_W_DEF             = 5;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [31:0] mask;
        logic [31:0] oq;
        logic [31:0] nh;
    } lpm_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_SCAN  = 2'd2,
        ST_RESP  = 2'd3
    } lpm_state_t;

    function automatic logic entry_match(input logic valid, input logic [31:0] entry_ip,
                                         input logic [31:0] mask, input logic [31:0] ip);
        return valid && ((ip & mask) == (entry_ip & mask));
    endfunction

endpackage

// File: rtl/lpm_chunk_match.sv
// Combinational best-of-chunk search: longest mask among matching entries, lowest index on ties.
import lpm_pkg::*;

module lpm_chunk_match #(
    parameter int ENTRIES_PER_CYCLE = ENTRIES_PER_CYCLE_DEF,
    parameter int IDX_W             = IDX_W_DEF
) (
    input  logic [31:0]                        ip,
    input  logic [ENTRIES_PER_CYCLE-1:0]       ent_valid,
    input  logic [ENTRIES_PER_CYCLE-1:0][31:0] ent_ip,
    input  logic [ENTRIES_PER_CYCLE-1:0][31:0] ent_mask,
    input  logic [IDX_W-1:0]                   base_idx,
    output logic                               chunk_hit,
    output logic [31:0]                        chunk_mask,
    output logic [IDX_W-1:0]                   chunk_idx
);

    logic [ENTRIES_PER_CYCLE-1:0] match;

    generate
        for (genvar gi = 0; gi < ENTRIES_PER_CYCLE; gi++) begin : g_match
            assign match[gi] = entry_match(ent_valid[gi], ent_ip[gi], ent_mask[gi], ip);
        end
    endgenerate

    // Ascending scan with strict compare keeps the lowest index on equal masks.
    always_comb begin
        chunk_hit  = 1'b0;
        chunk_mask = '0;
        chunk_idx  = base_idx;
        for (int i = 0; i < ENTRIES_PER_CYCLE; i++) begin
            if (match[i] && (!chunk_hit || ent_mask[i] > chunk_mask)) begin
                chunk_hit  = 1'b1;
                chunk_mask = ent_mask[i];
                chunk_idx  = base_idx + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lpm_table_ctrl.sv
// LPM routing table with lookup/write arbitration and a multi-cycle chunked scan.
// Define LPM_STATS_EN to build the hit/miss counters and their stats_clr/count ports.
import lpm_pkg::*;

module lpm_table_ctrl #(
    parameter int NUM_ENTRIES       = NUM_ENTRIES_DEF,
    parameter int ENTRIES_PER_CYCLE = ENTRIES_PER_CYCLE_DEF,
    parameter int IDX_W             = IDX_W_DEF
) (
    input  logic             AXI_ACLK,
    input  logic             AXI_RESETN,
    input  logic             lkp_req_valid,
    output logic             lkp_req_ready,
    input  logic [31:0]      lkp_req_ip,
    output logic             lkp_rsp_valid,
    input  logic             lkp_rsp_ready,
    output logic             lkp_hit,
    output logic [IDX_W-1:0] lkp_index,
    output logic [31:0]      lkp_oq,
    output logic [31:0]      lkp_nh,
    input  logic             wr_req,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [31:0]      wr_ip,
    input  logic [31:0]      wr_mask,
    input  logic [31:0]      wr_oq,
    input  logic [31:0]      wr_nh,
    input  logic             wr_entry_valid,
`ifdef LPM_STATS_EN
    input  logic             stats_clr,
    output logic [31:0]      lpm_hit_count,
    output logic [31:0]      lpm_miss_count,
`endif
    output logic             wr_ack
);

    localparam int NUM_CHUNKS = NUM_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    lpm_entry_t       table_reg [NUM_ENTRIES];
    lpm_state_t       state_reg;
    logic             last_wr_reg;
    logic [31:0]      ip_reg;
    logic [CHUNK_W-1:0] chunk_reg;
    logic             best_valid_reg;
    logic [31:0]      best_mask_reg;
    logic [IDX_W-1:0] best_idx_reg;

    logic             rsp_valid_reg, hit_reg, wr_ack_reg;
    logic [IDX_W-1:0] index_reg;
    logic [31:0]      oq_reg, nh_reg;

    // A pending write is served first unless the previous grant already went to a write.
    logic lkp_accept, wr_grant;
    assign lkp_req_ready = AXI_RESETN && (state_reg == ST_IDLE) && !(wr_req && !last_wr_reg);
    assign lkp_accept    = lkp_req_valid && lkp_req_ready;
    assign wr_grant      = (state_reg == ST_IDLE) && wr_req && !lkp_accept;

    logic [IDX_W-1:0]                   chunk_base;
    logic [ENTRIES_PER_CYCLE-1:0]       ck_valid;
    logic [ENTRIES_PER_CYCLE-1:0][31:0] ck_ip, ck_mask;
    assign chunk_base = IDX_W'(int'(chunk_reg) * ENTRIES_PER_CYCLE);

    generate
        for (genvar gi = 0; gi < ENTRIES_PER_CYCLE; gi++) begin : g_chunk
            assign ck_valid[gi] = table_reg[chunk_base + IDX_W'(gi)].valid;
            assign ck_ip[gi]    = table_reg[chunk_base + IDX_W'(gi)].ip;
            assign ck_mask[gi]  = table_reg[chunk_base + IDX_W'(gi)].mask;
        end
    endgenerate

    logic             c_hit;
    logic [31:0]      c_mask;
    logic [IDX_W-1:0] c_idx;

    lpm_chunk_match #(
        .ENTRIES_PER_CYCLE (ENTRIES_PER_CYCLE),
        .IDX_W             (IDX_W)
    ) u_chunk_match (
        .ip         (ip_reg),
        .ent_valid  (ck_valid),
        .ent_ip     (ck_ip),
        .ent_mask   (ck_mask),
        .base_idx   (chunk_base),
        .chunk_hit  (c_hit),
        .chunk_mask (c_mask),
        .chunk_idx  (c_idx)
    );

    logic             next_valid;
    logic [31:0]      next_mask;
    logic [IDX_W-1:0] next_idx;

    // Later chunks hold higher indices, so they replace the running best only on a strictly longer mask.
    always_comb begin
        next_valid = best_valid_reg;
        next_mask  = best_mask_reg;
        next_idx   = best_idx_reg;
        if (c_hit && (!best_valid_reg || c_mask > best_mask_reg)) begin
            next_valid = 1'b1;
            next_mask  = c_mask;
            next_idx   = c_idx;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            state_reg      <= ST_IDLE;
            last_wr_reg    <= 1'b0;
            ip_reg         <= '0;
            chunk_reg      <= '0;
            best_valid_reg <= 1'b0;
            best_mask_reg  <= '0;
            best_idx_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            hit_reg        <= 1'b0;
            index_reg      <= '0;
            oq_reg         <= '0;
            nh_reg         <= '0;
            wr_ack_reg     <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                table_reg[i].valid <= 1'b0;
            end
        end else begin
            wr_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (lkp_accept) begin
                        ip_reg         <= lkp_req_ip;
                        chunk_reg      <= '0;
                        best_valid_reg <= 1'b0;
                        best_mask_reg  <= '0;
                        best_idx_reg   <= '0;
                        last_wr_reg    <= 1'b0;
                        state_reg      <= ST_SCAN;
                    end else if (wr_grant) begin
                        // The entry lands on the grant edge; WRITE is the acknowledge cycle.
                        table_reg[wr_index] <= '{valid: wr_entry_valid, ip: wr_ip, mask: wr_mask,
                                                 oq: wr_oq, nh: wr_nh};
                        wr_ack_reg  <= 1'b1;
                        last_wr_reg <= 1'b1;
                        state_reg   <= ST_WRITE;
                    end
                end
                ST_WRITE: state_reg <= ST_IDLE;
                ST_SCAN: begin
                    best_valid_reg <= next_valid;
                    best_mask_reg  <= next_mask;
                    best_idx_reg   <= next_idx;
                    chunk_reg      <= chunk_reg + 1'b1;
                    if (chunk_reg == LAST_CHUNK) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        hit_reg       <= next_valid;
                        index_reg     <= next_valid ? next_idx : '0;
                        oq_reg        <= next_valid ? table_reg[next_idx].oq : '0;
                        nh_reg        <= next_valid ? table_reg[next_idx].nh : '0;
                    end
                end
                ST_RESP: begin
                    if (lkp_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign lkp_rsp_valid = rsp_valid_reg;
    assign lkp_hit       = hit_reg;
    assign lkp_index     = index_reg;
    assign lkp_oq        = oq_reg;
    assign lkp_nh        = nh_reg;
    assign wr_ack        = wr_ack_reg;

`ifdef LPM_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN || stats_clr) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (rsp_valid_reg && lkp_rsp_ready) begin
            if (hit_reg) hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            else         miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign lpm_hit_count  = hit_cnt_reg;
    assign lpm_miss_count = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_lpm_table_ctrl.sv
// Self-checking bench for lpm_table_ctrl: directed vectors, arbitration/stall/reset sequences, random vs. model.
// Counter checks are compiled in when LPM_STATS_EN is defined.
module tb_lpm_table_ctrl;

    localparam int NE  = 32;
    localparam int EPC = 4;
    localparam int LAT = NE / EPC + 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lkp_req_valid, lkp_req_ready, lkp_rsp_valid, lkp_rsp_ready, lkp_hit;
    logic [31:0] lkp_req_ip, lkp_oq, lkp_nh;
    logic [4:0]  lkp_index, wr_index;
    logic        wr_req, wr_ack, wr_entry_valid;
    logic [31:0] wr_ip, wr_mask, wr_oq, wr_nh;
`ifdef LPM_STATS_EN
    logic        stats_clr;
    logic [31:0] lpm_hit_count, lpm_miss_count;
`endif

    always #5 clk = ~clk;

    lpm_table_ctrl dut (
        .AXI_ACLK       (clk),
        .AXI_RESETN     (rstn),
        .lkp_req_valid  (lkp_req_valid),
        .lkp_req_ready  (lkp_req_ready),
        .lkp_req_ip     (lkp_req_ip),
        .lkp_rsp_valid  (lkp_rsp_valid),
        .lkp_rsp_ready  (lkp_rsp_ready),
        .lkp_hit        (lkp_hit),
        .lkp_index      (lkp_index),
        .lkp_oq         (lkp_oq),
        .lkp_nh         (lkp_nh),
        .wr_req         (wr_req),
        .wr_index       (wr_index),
        .wr_ip          (wr_ip),
        .wr_mask        (wr_mask),
        .wr_oq          (wr_oq),
        .wr_nh          (wr_nh),
        .wr_entry_valid (wr_entry_valid),
`ifdef LPM_STATS_EN
        .stats_clr      (stats_clr),
        .lpm_hit_count  (lpm_hit_count),
        .lpm_miss_count (lpm_miss_count),
`endif
        .wr_ack         (wr_ack)
    );

    int checks = 0;
    int errors = 0;
    int t_hit  = 0;
    int t_miss = 0;

    // Reference table: plain arrays, lookup is a linear search over all entries.
    logic        m_valid [NE];
    logic [31:0] m_ip [NE], m_mask [NE], m_oq [NE], m_nh [NE];

    function automatic int ref_best(input logic [31:0] ip);
        int best = -1;
        for (int i = 0; i < NE; i++) begin
            if (m_valid[i] && (((ip ^ m_ip[i]) & m_mask[i]) == 32'd0)) begin
                if (best < 0 || m_mask[i] > m_mask[best]) best = i;
            end
        end
        return best;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic check_vs_model(input string tag, input logic [31:0] ip, input logic h,
                                  input logic [4:0] i, input logic [31:0] o, input logic [31:0] n);
        int b = ref_best(ip);
        check({tag, "_hit"},   32'(h), (b >= 0) ? 32'd1 : 32'd0);
        check({tag, "_index"}, 32'(i), (b >= 0) ? 32'(b) : 32'd0);
        check({tag, "_oq"},    o,      (b >= 0) ? m_oq[b] : 32'd0);
        check({tag, "_nh"},    n,      (b >= 0) ? m_nh[b] : 32'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        t_hit  = 0;
        t_miss = 0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] ip, input logic [31:0] mask,
                               input logic [31:0] oq, input logic [31:0] nh, input logic v);
        m_valid[idx] = v;
        m_ip[idx]    = ip;
        m_mask[idx]  = mask;
        m_oq[idx]    = oq;
        m_nh[idx]    = nh;
    endtask

    task automatic tally(input logic [31:0] ip);
        if (ref_best(ip) >= 0) t_hit++;
        else t_miss++;
    endtask

    task automatic set_wr(input int idx, input logic [31:0] ip, input logic [31:0] mask,
                          input logic [31:0] oq, input logic [31:0] nh, input logic v);
        wr_index = 5'(idx);
        wr_ip = ip;
        wr_mask = mask;
        wr_oq = oq;
        wr_nh = nh;
        wr_entry_valid = v;
    endtask

    task automatic write_entry(input int idx, input logic [31:0] ip, input logic [31:0] mask,
                               input logic [31:0] oq, input logic [31:0] nh, input logic v);
        bit ok = 0;
        set_wr(idx, ip, mask, oq, nh, v);
        wr_req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (wr_ack) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        if (ok) begin
            model_write(idx, ip, mask, oq, nh, v);
            $display("write idx=%0d ip=%08h mask=%08h oq=%08h nh=%08h valid=%0d", idx, ip, mask, oq, nh, v);
        end else begin
            fail("write_ack");
        end
    endtask

    // Returns one cycle after the accepting edge (T+#1).
    task automatic start_lookup(input logic [31:0] ip);
        bit ok = 0;
        lkp_req_ip = ip;
        lkp_req_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (lkp_req_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        lkp_req_valid = 1'b0;
        if (!ok) fail("lookup_accept");
    endtask

    // lat = cycle number (relative to the accepting edge) at which the consumer first samples valid.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            lat++;
            if (lkp_rsp_valid) break;
        end
        if (!lkp_rsp_valid) fail("lookup_response");
    endtask

    task automatic do_lookup(input logic [31:0] ip, output logic h, output logic [4:0] i,
                             output logic [31:0] o, output logic [31:0] n, output int lat);
        start_lookup(ip);
        wait_rsp(lat);
        h = lkp_hit;
        i = lkp_index;
        o = lkp_oq;
        n = lkp_nh;
        $display("lookup ip=%08h hit=%0d idx=%0d oq=%08h nh=%08h lat=%0d", ip, h, i, o, n, lat);
        if (lkp_rsp_valid && lkp_rsp_ready) tally(ip);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ip;
        logic        exp_hit;
        logic [4:0]  exp_idx;
        logic [31:0] exp_oq;
        logic [31:0] exp_nh;
    } vec_t;

    vec_t        vecs [7];
    logic        h;
    logic [4:0]  ix;
    logic [31:0] oq, nh, ip;
    int          lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        lkp_req_valid = 1'b0;
        lkp_req_ip = '0;
        lkp_rsp_ready = 1'b1;
        wr_req = 1'b0;
        set_wr(0, 0, 0, 0, 0, 1'b0);
`ifdef LPM_STATS_EN
        stats_clr = 1'b0;
`endif
        model_clear();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(lkp_req_ready), 0);
        check("rst_rsp_valid", 32'(lkp_rsp_valid), 0);
        check("rst_hit", 32'(lkp_hit), 0);
        check("rst_index", 32'(lkp_index), 0);
        check("rst_oq", lkp_oq, 0);
        check("rst_nh", lkp_nh, 0);
        check("rst_wr_ack", 32'(wr_ack), 0);
`ifdef LPM_STATS_EN
        check("rst_hit_count", lpm_hit_count, 0);
        check("rst_miss_count", lpm_miss_count, 0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(lkp_req_ready), 1);
        @(posedge clk);
        #1;

        // Empty table misses
        do_lookup($urandom, h, ix, oq, nh, lat);
        check("empty_hit", 32'(h), 0);
        check("empty_index", 32'(ix), 0);
        check("empty_oq", oq, 0);
        check("empty_nh", nh, 0);
        check("empty_latency", 32'(lat), 32'(LAT));
`ifdef LPM_STATS_EN
        check("empty_miss_count", lpm_miss_count, 1);
`endif

        // Directed table and vectors
        write_entry(3, 32'h0A000000, 32'hFFFF0000, 32'd1, 32'h0A000001, 1'b1);
        write_entry(7, 32'h0A000100, 32'hFFFFFF00, 32'd4, 32'h0A000101, 1'b1);
        write_entry(2, 32'hC0A80500, 32'hFFFFFF00, 32'd2, 32'hC0A80501, 1'b1);
        write_entry(9, 32'hC0A80500, 32'hFFFFFF00, 32'd9, 32'hC0A80509, 1'b1);
        vecs[0] = '{32'h0A000105, 1'b1, 5'd7, 32'd4, 32'h0A000101};
        vecs[1] = '{32'h0A00FF01, 1'b1, 5'd3, 32'd1, 32'h0A000001};
        vecs[2] = '{32'hC0A80563, 1'b1, 5'd2, 32'd2, 32'hC0A80501};
        vecs[3] = '{32'h0B000105, 1'b0, 5'd0, 32'd0, 32'd0};
        vecs[4] = '{32'h0A000100, 1'b1, 5'd7, 32'd4, 32'h0A000101};
        vecs[5] = '{32'h0A0001FF, 1'b1, 5'd7, 32'd4, 32'h0A000101};
        vecs[6] = '{32'h0A010105, 1'b0, 5'd0, 32'd0, 32'd0};
        for (int k = 0; k < 7; k++) begin
            do_lookup(vecs[k].ip, h, ix, oq, nh, lat);
            check($sformatf("vec%0d_hit", k), 32'(h), 32'(vecs[k].exp_hit));
            check($sformatf("vec%0d_index", k), 32'(ix), 32'(vecs[k].exp_idx));
            check($sformatf("vec%0d_oq", k), oq, vecs[k].exp_oq);
            check($sformatf("vec%0d_nh", k), nh, vecs[k].exp_nh);
            if (k == 0) check("vec0_latency", 32'(lat), 32'(LAT));
        end

        // Simultaneous write and lookup in IDLE: write, then lookup, then the held write again
        begin
            int ack1 = -1, ack2 = -1, acc = -1, rsp = -1;
            set_wr(5, 32'h0A000100, 32'hFFFFFF80, 32'd5, 32'h0A000105, 1'b1);
            lkp_req_ip = 32'h0A000105;
            lkp_req_valid = 1'b1;
            wr_req = 1'b1;
            for (int c = 0; c < 60 && ack2 < 0; c++) begin
                @(negedge clk);
                if (wr_ack) begin
                    if (ack1 < 0) begin
                        ack1 = c;
                        model_write(5, 32'h0A000100, 32'hFFFFFF80, 32'd5, 32'h0A000105, 1'b1);
                    end else begin
                        ack2 = c;
                    end
                end
                if (lkp_req_valid && lkp_req_ready && acc < 0) acc = c;
                if (lkp_rsp_valid && lkp_rsp_ready && rsp < 0) begin
                    rsp = c;
                    check_vs_model("arb_lookup", 32'h0A000105, lkp_hit, lkp_index, lkp_oq, lkp_nh);
                    tally(32'h0A000105);
                end
                @(posedge clk);
                #1;
                if (acc >= 0) lkp_req_valid = 1'b0;
                if (ack2 >= 0) wr_req = 1'b0;
            end
            wr_req = 1'b0;
            lkp_req_valid = 1'b0;
            $display("arbitration ack1=%0d accept=%0d rsp=%0d ack2=%0d", ack1, acc, rsp, ack2);
            check("arb_first_ack", 32'(ack1), 1);
            check("arb_lookup_accept", 32'(acc), 2);
            check("arb_rsp_cycle", 32'(rsp), 32'(acc + LAT));
            check("arb_second_ack", 32'(ack2), 32'(rsp + 2));
            check("arb_index_new_entry", 32'(ref_best(32'h0A000105)), 5);
        end

        // Write raised during scan cycle 3 waits for the response; scan sees the old table
        begin
            int ack = -1, rsp = -1;
            start_lookup(32'h0A000105);
            repeat (2) @(posedge clk);
            #1;
            set_wr(12, 32'h0A000104, 32'hFFFFFFFC, 32'd12, 32'h0A00010C, 1'b1);
            wr_req = 1'b1;
            for (int c = 0; c < 60 && ack < 0; c++) begin
                @(negedge clk);
                if (wr_ack) ack = c;
                if (lkp_rsp_valid && rsp < 0) begin
                    rsp = c;
                    check_vs_model("scanwr_old", 32'h0A000105, lkp_hit, lkp_index, lkp_oq, lkp_nh);
                    tally(32'h0A000105);
                end
                @(posedge clk);
                #1;
                if (ack >= 0) wr_req = 1'b0;
            end
            wr_req = 1'b0;
            $display("write during scan rsp=%0d ack=%0d", rsp, ack);
            check("scanwr_ack_after_rsp", 32'(ack), 32'(rsp + 2));
            model_write(12, 32'h0A000104, 32'hFFFFFFFC, 32'd12, 32'h0A00010C, 1'b1);
            do_lookup(32'h0A000105, h, ix, oq, nh, lat);
            check_vs_model("scanwr_new", 32'h0A000105, h, ix, oq, nh);
            check("scanwr_new_index", 32'(ix), 12);
        end

        // Downstream stall: outputs hold and no new lookup is accepted
        lkp_rsp_ready = 1'b0;
        start_lookup(32'hC0A80563);
        wait_rsp(lat);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stall%0d_valid", k), 32'(lkp_rsp_valid), 1);
            check($sformatf("stall%0d_req_ready", k), 32'(lkp_req_ready), 0);
            check_vs_model($sformatf("stall%0d", k), 32'hC0A80563, lkp_hit, lkp_index, lkp_oq, lkp_nh);
            if (k < 5) @(negedge clk);
        end
        lkp_rsp_ready = 1'b1;
        tally(32'hC0A80563);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_released_valid", 32'(lkp_rsp_valid), 0);
        @(posedge clk);
        #1;

        // Reset pulsed mid-scan: response dropped, table emptied
        begin
            int seen = 0;
            start_lookup(32'h0A000105);
            repeat (3) @(posedge clk);
            #1;
            rstn = 1'b0;
            @(posedge clk);
            #1;
            rstn = 1'b1;
            model_clear();
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (lkp_rsp_valid) seen++;
            end
            check("midscan_rst_no_rsp", 32'(seen), 0);
            @(posedge clk);
            #1;
            do_lookup(32'h0A000105, h, ix, oq, nh, lat);
            check("midscan_rst_next_hit", 32'(h), 0);
            check_vs_model("midscan_rst_next", 32'h0A000105, h, ix, oq, nh);
        end

        // Random table contents and lookups against the model
        for (int k = 0; k < 14; k++) begin
            int plen;
            logic [31:0] ones, msk;
            ones = '1;
            plen = 8 * $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) plen = $urandom_range(0, 32);
            msk  = (plen == 0) ? 32'd0 : (ones << (32 - plen));
            write_entry($urandom_range(0, NE - 1), {8'd10, 8'($urandom_range(0, 1)), 16'($urandom)},
                        msk, $urandom, $urandom, $urandom_range(0, 5) != 0);
        end
        for (int k = 0; k < 24; k++) begin
            ip = {8'($urandom_range(10, 11)), 8'($urandom_range(0, 1)), 16'($urandom)};
            do_lookup(ip, h, ix, oq, nh, lat);
            check_vs_model($sformatf("rand%0d", k), ip, h, ix, oq, nh);
        end

`ifdef LPM_STATS_EN
        check("final_hit_count", lpm_hit_count, 32'(t_hit));
        check("final_miss_count", lpm_miss_count, 32'(t_miss));
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        check("clr_hit_count", lpm_hit_count, 0);
        check("clr_miss_count", lpm_miss_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lpm_table_ctrl.md
# lpm_table_ctrl

Owns the 32-entry longest-prefix-match routing table and arbitrates it between two requesters: the output-port-lookup datapath (lookup requests) and the host register interface (entry writes). Lookups scan the table several entries per cycle. Each lookup returns the hit flag, winning index, output queue and next hop to the downstream header-rewrite stage. Writes are applied only between scans, so a lookup never sees a half-updated table.

## Interface
- NUM_ENTRIES, 32, table depth; power of two.
- ENTRIES_PER_CYCLE, 4, entries compared per scan cycle; must divide NUM_ENTRIES.
- IDX_W, 5, log2(NUM_ENTRIES).
- AXI_ACLK  in  1  sole clock.
- AXI_RESETN  in  1  synchronous, active-low reset.
- lkp_req_valid  in  1  lookup request.
- lkp_req_ready  out  1  high only in IDLE when no write wins arbitration.
- lkp_req_ip  in  32  destination IP.
- lkp_rsp_valid  out  1  result valid; held until accepted.
- lkp_rsp_ready  in  1  downstream accept.
- lkp_hit  out  1  at least one valid entry matched.
- lkp_index  out  IDX_W  winning entry; 0 on miss.
- lkp_oq  out  32  output queue of winner; 0 on miss.
- lkp_nh  out  32  next hop of winner; 0 on miss.
- wr_req  in  1  host write request; held until wr_ack.
- wr_ack  out  1  one-cycle pulse when the write is committed.
- wr_index  in  IDX_W  target entry.
- wr_ip, wr_mask, wr_oq, wr_nh  in  32 each  entry fields.
- wr_entry_valid  in  1  0 invalidates the entry.
- stats_clr  in  1  clears counters (LPM_STATS_EN only).
- lpm_hit_count, lpm_miss_count  out  32 each  (LPM_STATS_EN only).

## Operation
- Entry match: valid && ((ip & mask) == (entry_ip & mask)).
- Longest prefix: the larger mask (unsigned compare) wins. On equal masks, the lower index wins.
- Per scan cycle, compare ENTRIES_PER_CYCLE entries against the running best (best_valid, best_mask, best_idx). A chunk candidate replaces the best only if strictly greater, so lower indices keep ties.
- FSM: IDLE, WRITE, SCAN, RESP.
  - IDLE with wr_req and lkp_req_valid both high: a write goes first unless the previous grant was a write (last_wr flag). This bounds each requester to one grant before the other is served.
  - IDLE -> WRITE on a write grant. WRITE commits the entry, pulses wr_ack, sets last_wr=1, and returns to IDLE.
  - IDLE -> SCAN on lookup handshake. Latch the IP, clear best, chunk counter=0, last_wr=0.
  - SCAN advances the chunk counter each cycle. After chunk NUM_ENTRIES/ENTRIES_PER_CYCLE-1, go to RESP; the counter wraps to 0.
  - RESP holds the result outputs stable until lkp_rsp_ready, then returns to IDLE.
- wr_req arriving during SCAN or RESP waits; wr_ack stays low.
- A write to the entry currently being scanned cannot occur, because writes are only applied between scans.
- Empty table (all entries invalid): every lookup misses with lkp_index=0, lkp_oq=0, lkp_nh=0.

## Timing
- Reset values: state=IDLE, all entry valid bits 0, last_wr=0, lkp_req_ready=0 during reset. lkp_rsp_valid, lkp_hit, lkp_index, lkp_oq, lkp_nh, wr_ack and the counters are all 0.
- Lookup accepted at edge T. Scan cycles run T+1 .. T+8 with the defaults. lkp_rsp_valid is high from T+9.
- Latency = NUM_ENTRIES/ENTRIES_PER_CYCLE + 1 cycles.
- Peak throughput: one lookup per 10 cycles, because IDLE consumes one cycle.
- Write latency: wr_ack in the cycle after the grant. The entry is visible to any scan that starts afterwards.
- Reset asserted mid-scan or in RESP: the in-flight response is dropped, the table is invalidated, and the FSM returns to IDLE on the next edge.

## Configuration
- LPM_STATS_EN defined: lpm_hit_count or lpm_miss_count increments on each lkp_rsp_valid && lkp_rsp_ready.
  - Both counters wrap modulo 2^32.
  - If stats_clr and an increment occur in the same cycle, the counter goes to 0.
- LPM_STATS_EN undefined: the counter ports and stats_clr are absent, and no counter logic is built.

## Structure
- Shared package lpm_pkg holds:
  - NUM_ENTRIES and IDX_W defaults.
  - lpm_entry_t typedef: valid, ip, mask, oq, nh.
  - FSM state encoding.
- Sub-module lpm_chunk_match: combinational. It takes ENTRIES_PER_CYCLE entries, the IP and a base index, and returns the chunk's best {hit, mask, idx}.

## Test plan
- Lookup ip 10.0.1.5 with entry 3 = 10.0.0.0/255.255.0.0 oq 1 and entry 7 = 10.0.1.0/255.255.255.0 oq 4 nh 10.0.1.1 -> hit=1, index=7, oq=4, nh=0x0A000101, response at T+9.
- Entries 2 and 9 identical at /24 -> index=2.
- Empty table, any IP -> hit=0, index=0, oq=0, nh=0; miss_count=1 with LPM_STATS_EN.
- wr_req and lkp_req_valid asserted together in IDLE:
  - write granted first (wr_ack at +1);
  - with both still held, the lookup is granted next;
  - a second write is granted only after that lookup's response handshake.
- wr_req raised at scan cycle 3 -> wr_ack only after the RESP handshake, and the scan result reflects the old table.
- lkp_rsp_ready held low 5 cycles -> outputs stable and lkp_req_ready=0 throughout. Reset pulsed in SCAN -> no response, the next lookup misses.
